// File: rtl/ram_arb2_pkg.sv
// Shared types and sizes for the two-master RAM arbiter.
// Holds the FSM state encoding, the RAM word/address widths and the
// request payload struct carried from a master to the RAM pins.
package ram_arb2_pkg;

    localparam int unsigned RAM_AW = 8;
    localparam int unsigned RAM_DW = 16;
    // Wide enough for the largest legal READ_LATENCY (3)
    localparam int unsigned CNT_W  = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    typedef struct packed {
        logic              we;
        logic [RAM_AW-1:0] addr;
        logic [RAM_DW-1:0] wdata;
    } ram_req_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker.
// Ports: clk, rst (async, active-high); req0/req1 requests;
//        take updates the last-served pointer to the current winner;
//        gnt0/gnt1 combinational one-hot (or zero) grant.
module rr_pick2 (
    input  logic clk,
    input  logic rst,
    input  logic req0,
    input  logic req1,
    input  logic take,
    output logic gnt0,
    output logic gnt1
);

    // 1 = master 1 was served last, so master 0 wins the first tie
    logic last;

    // On a tie the master that is not 'last' wins
    always_comb begin
        gnt0 = req0 & (~req1 | last);
        gnt1 = req1 & (~req0 | ~last);
    end

    // take is only asserted together with a grant, so gnt1 names the winner
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last <= 1'b1;
        end else if (take) begin
            last <= gnt1;
        end
    end

endmodule

// File: rtl/ram_arb2.sv
// Two-master arbiter/sequencer for a single-port RAM with registered read data.
// Ports: clk, rst (async, active-high)
//        m0_*/m1_*: req/we/addr/wdata in, ack (one-cycle pulse) and rdata out
//        ram_addr/ram_din/ram_we: registered RAM pins; ram_dout: RAM read data
// A transaction runs IDLE -> ACCESS -> (WAIT x READ_LATENCY for reads) -> DONE.
module ram_arb2
    import ram_arb2_pkg::*;
#(
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [RAM_AW-1:0] m0_addr,
    input  logic [RAM_DW-1:0] m0_wdata,
    output logic              m0_ack,
    output logic [RAM_DW-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [RAM_AW-1:0] m1_addr,
    input  logic [RAM_DW-1:0] m1_wdata,
    output logic              m1_ack,
    output logic [RAM_DW-1:0] m1_rdata,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [RAM_DW-1:0] ram_din,
    output logic              ram_we,
    input  logic [RAM_DW-1:0] ram_dout
);

    state_e            state_q, state_d;
    logic              sel_q, sel_d;        // granted master
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [RAM_AW-1:0] ram_addr_d;
    logic [RAM_DW-1:0] ram_din_d;
    logic              ram_we_d;
    logic              m0_ack_d, m1_ack_d;
    logic [RAM_DW-1:0] m0_rdata_d, m1_rdata_d;

    logic              gnt0, gnt1, take;
    ram_req_t          req0_p, req1_p, pick;

    assign req0_p = '{we: m0_we, addr: m0_addr, wdata: m0_wdata};
    assign req1_p = '{we: m1_we, addr: m1_addr, wdata: m1_wdata};
    assign pick   = gnt1 ? req1_p : req0_p;
    assign take   = (state_q == ST_IDLE) && (gnt0 || gnt1);

    rr_pick2 u_pick (
        .clk  (clk),
        .rst  (rst),
        .req0 (m0_req),
        .req1 (m1_req),
        .take (take),
        .gnt0 (gnt0),
        .gnt1 (gnt1)
    );

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            sel_q    <= 1'b0;
            cnt_q    <= '0;
            ram_addr <= '0;
            ram_din  <= '0;
            ram_we   <= 1'b0;
            m0_ack   <= 1'b0;
            m1_ack   <= 1'b0;
            m0_rdata <= '0;
            m1_rdata <= '0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            cnt_q    <= cnt_d;
            ram_addr <= ram_addr_d;
            ram_din  <= ram_din_d;
            ram_we   <= ram_we_d;
            m0_ack   <= m0_ack_d;
            m1_ack   <= m1_ack_d;
            m0_rdata <= m0_rdata_d;
            m1_rdata <= m1_rdata_d;
        end
    end

    // Next state and next register values; ram_we and acks default low
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        cnt_d      = cnt_q;
        ram_addr_d = ram_addr;
        ram_din_d  = ram_din;
        ram_we_d   = 1'b0;
        m0_ack_d   = 1'b0;
        m1_ack_d   = 1'b0;
        m0_rdata_d = m0_rdata;
        m1_rdata_d = m1_rdata;

        case (state_q)
            ST_IDLE: begin
                if (take) begin
                    sel_d      = gnt1;
                    ram_addr_d = pick.addr;
                    ram_din_d  = pick.wdata;
                    ram_we_d   = pick.we;
                    state_d    = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                // ram_we still reflects the granted request's direction here
                if (ram_we) begin
                    m0_ack_d = ~sel_q;
                    m1_ack_d = sel_q;
                    state_d  = ST_DONE;
                end else begin
                    cnt_d   = CNT_W'(READ_LATENCY);
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                // Last wait cycle: ram_dout now holds the addressed word
                if (cnt_q == CNT_W'(1)) begin
                    if (sel_q) begin
                        m1_rdata_d = ram_dout;
                    end else begin
                        m0_rdata_d = ram_dout;
                    end
                    m0_ack_d = ~sel_q;
                    m1_ack_d = sel_q;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ram_arb2.sv
// Directed bench for ram_arb2: one instance at READ_LATENCY=1 and one at 2,
// each beside a small behavioural RAM with registered read data.
module tb_ram_arb2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    // READ_LATENCY = 1 instance
    logic        m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
    logic [7:0]  m0_addr = '0, m1_addr = '0;
    logic [15:0] m0_wdata = '0, m1_wdata = '0;
    logic        m0_ack, m1_ack, ram_we;
    logic [15:0] m0_rdata, m1_rdata, ram_din, ram_dout;
    logic [7:0]  ram_addr;

    // READ_LATENCY = 2 instance (master 1 idle)
    logic        p0_req = 1'b0, p0_we = 1'b0, p1_req = 1'b0, p1_we = 1'b0;
    logic [7:0]  p0_addr = '0, p1_addr = '0;
    logic [15:0] p0_wdata = '0, p1_wdata = '0;
    logic        p0_ack, p1_ack, r2_we;
    logic [15:0] p0_rdata, p1_rdata, r2_din, r2_dout, r2_stage;
    logic [7:0]  r2_addr;

    logic [15:0] mem1 [256];
    logic [15:0] mem2 [256];

    int nchecks = 0;
    int nfail   = 0;

    always #5 clk = ~clk;

    ram_arb2 #(.READ_LATENCY(1)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout)
    );

    ram_arb2 #(.READ_LATENCY(2)) dut2 (
        .clk(clk), .rst(rst),
        .m0_req(p0_req), .m0_we(p0_we), .m0_addr(p0_addr), .m0_wdata(p0_wdata),
        .m0_ack(p0_ack), .m0_rdata(p0_rdata),
        .m1_req(p1_req), .m1_we(p1_we), .m1_addr(p1_addr), .m1_wdata(p1_wdata),
        .m1_ack(p1_ack), .m1_rdata(p1_rdata),
        .ram_addr(r2_addr), .ram_din(r2_din), .ram_we(r2_we), .ram_dout(r2_dout)
    );

    // Read-first RAM, one output register
    always @(posedge clk) begin
        if (ram_we) mem1[ram_addr] <= ram_din;
        ram_dout <= mem1[ram_addr];
    end

    // Read-first RAM, two output registers
    always @(posedge clk) begin
        if (r2_we) mem2[r2_addr] <= r2_din;
        r2_stage <= mem2[r2_addr];
        r2_dout  <= r2_stage;
    end

    task automatic set_req(input int d, input int m, input logic req, input logic we,
                           input logic [7:0] a, input logic [15:0] wd);
        if (d == 1) begin
            p0_req = req; p0_we = we; p0_addr = a; p0_wdata = wd;
        end else if (m == 0) begin
            m0_req = req; m0_we = we; m0_addr = a; m0_wdata = wd;
        end else begin
            m1_req = req; m1_we = we; m1_addr = a; m1_wdata = wd;
        end
    endtask

    // One transaction; k = cycle offset of ack from the IDLE sampling cycle, -1 on timeout
    task automatic run_txn(input int d, input int m, input logic we, input logic [7:0] a,
                           input logic [15:0] wd, output int k, output logic [15:0] rd,
                           output int we_cyc, output int other);
        logic ack_s, ack_o, wep;
        logic [15:0] rds;
        bit done;
        @(posedge clk); #1;
        set_req(d, m, 1'b1, we, a, wd);
        k = -1; rd = '0; we_cyc = 0; other = 0; done = 0;
        for (int c = 0; c < 12 && !done; c++) begin
            @(negedge clk);
            if (d == 1) begin
                ack_s = p0_ack; ack_o = p1_ack; rds = p0_rdata; wep = r2_we;
            end else begin
                ack_s = (m == 0) ? m0_ack : m1_ack;
                ack_o = (m == 0) ? m1_ack : m0_ack;
                rds   = (m == 0) ? m0_rdata : m1_rdata;
                wep   = ram_we;
            end
            if (wep) we_cyc++;
            if (ack_o) other++;
            if (ack_s) begin
                k = c; rd = rds; done = 1;
            end
            @(posedge clk); #1;
        end
        set_req(d, m, 1'b0, 1'b0, a, wd);
    endtask

    // Both masters request in the same cycle; each drops req right after its ack
    task automatic run_pair(input logic we, input logic [7:0] a0, input logic [15:0] d0,
                            input logic [7:0] a1, input logic [15:0] d1,
                            output int k0, output int k1,
                            output logic [15:0] rd0, output logic [15:0] rd1,
                            output int dbl);
        bit drop0, drop1;
        @(posedge clk); #1;
        set_req(0, 0, 1'b1, we, a0, d0);
        set_req(0, 1, 1'b1, we, a1, d1);
        k0 = -1; k1 = -1; rd0 = '0; rd1 = '0; dbl = 0; drop0 = 0; drop1 = 0;
        for (int c = 0; c < 20 && !(drop0 && drop1); c++) begin
            @(negedge clk);
            if (m0_ack && m1_ack) dbl++;
            if (m0_ack) begin k0 = c; rd0 = m0_rdata; drop0 = 1; end
            if (m1_ack) begin k1 = c; rd1 = m1_rdata; drop1 = 1; end
            @(posedge clk); #1;
            if (drop0) m0_req = 1'b0;
            if (drop1) m1_req = 1'b0;
        end
        m0_req = 1'b0; m1_req = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        m0_req = 1'b0; m1_req = 1'b0; p0_req = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        nchecks++;
        if ({ram_we, ram_addr, ram_din} !== 25'd0) begin
            nfail++; $display("FAIL reset_ram_pins got=%h exp=0", {ram_we, ram_addr, ram_din});
        end
        nchecks++;
        if ({m0_ack, m1_ack, m0_rdata, m1_rdata} !== 34'd0) begin
            nfail++; $display("FAIL reset_master_out got=%h exp=0", {m0_ack, m1_ack, m0_rdata, m1_rdata});
        end
        @(posedge clk); #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        nchecks++;
        if ({ram_we, m0_ack, m1_ack, ram_addr} !== 11'd0) begin
            nfail++; $display("FAIL idle_no_req got=%h exp=0", {ram_we, m0_ack, m1_ack, ram_addr});
        end
    endtask

    task automatic test_write_read();
        int k, wc, oth;
        logic [15:0] rd;
        run_txn(0, 0, 1'b1, 8'h12, 16'hBEEF, k, rd, wc, oth);
        nchecks++;
        if (k !== 2 || wc !== 1 || oth !== 0) begin
            nfail++; $display("FAIL wr_timing k=%0d we_cyc=%0d other=%0d exp k=2 we_cyc=1 other=0", k, wc, oth);
        end
        @(negedge clk);
        nchecks++;
        if (m0_ack !== 1'b0) begin
            nfail++; $display("FAIL ack_one_cycle got=%b exp=0", m0_ack);
        end
        run_txn(0, 0, 1'b0, 8'h12, 16'h0000, k, rd, wc, oth);
        nchecks++;
        if (k !== 3 || rd !== 16'hBEEF || wc !== 0) begin
            nfail++; $display("FAIL rd_beef k=%0d rd=%h we_cyc=%0d exp k=3 rd=beef we_cyc=0", k, rd, wc);
        end
    endtask

    task automatic test_tie();
        int k, wc, oth, k0, k1, dbl;
        logic [15:0] rd, rd0, rd1;
        run_txn(0, 0, 1'b1, 8'h00, 16'h1111, k, rd, wc, oth);
        run_txn(0, 1, 1'b1, 8'hFF, 16'h2222, k, rd, wc, oth);
        run_pair(1'b0, 8'h00, 16'h0, 8'hFF, 16'h0, k0, k1, rd0, rd1, dbl);
        nchecks++;
        if (k0 !== 3 || rd0 !== 16'h1111) begin
            nfail++; $display("FAIL tie_m0_first k0=%0d rd0=%h exp k0=3 rd0=1111", k0, rd0);
        end
        nchecks++;
        if (k1 !== 7 || rd1 !== 16'h2222 || dbl !== 0) begin
            nfail++; $display("FAIL tie_m1_next k1=%0d rd1=%h dbl=%0d exp k1=7 rd1=2222 dbl=0", k1, rd1, dbl);
        end
        // m1 served last, so the next tie again goes to m0
        run_pair(1'b1, 8'h30, 16'h3030, 8'h31, 16'h3131, k0, k1, rd0, rd1, dbl);
        nchecks++;
        if (k0 !== 2 || k1 !== 5) begin
            nfail++; $display("FAIL last_is_1 k0=%0d k1=%0d exp k0=2 k1=5", k0, k1);
        end
    endtask

    task automatic test_m1_only();
        int k, wc, oth;
        logic [15:0] rd;
        run_txn(0, 1, 1'b1, 8'h3C, 16'h0042, k, rd, wc, oth);
        run_txn(0, 1, 1'b0, 8'h3C, 16'h0000, k, rd, wc, oth);
        nchecks++;
        if (k !== 3 || rd !== 16'h0042 || oth !== 0) begin
            nfail++; $display("FAIL m1_read k=%0d rd=%h m0_acks=%0d exp k=3 rd=0042 m0_acks=0", k, rd, oth);
        end
        nchecks++;
        if (m0_rdata !== 16'h1111) begin
            nfail++; $display("FAIL m0_rdata_hold got=%h exp=1111", m0_rdata);
        end
    endtask

    task automatic test_wrap();
        int k, wc, oth;
        logic [15:0] rd;
        run_txn(0, 0, 1'b1, 8'hFF, 16'hAAAA, k, rd, wc, oth);
        run_txn(0, 0, 1'b1, 8'h00, 16'h5555, k, rd, wc, oth);
        run_txn(0, 0, 1'b0, 8'hFF, 16'h0000, k, rd, wc, oth);
        nchecks++;
        if (rd !== 16'hAAAA) begin
            nfail++; $display("FAIL wrap_ff got=%h exp=aaaa", rd);
        end
        run_txn(0, 0, 1'b0, 8'h00, 16'h0000, k, rd, wc, oth);
        nchecks++;
        if (rd !== 16'h5555) begin
            nfail++; $display("FAIL wrap_00 got=%h exp=5555", rd);
        end
    endtask

    task automatic test_req_drop();
        int k;
        logic [15:0] rd;
        @(posedge clk); #1;
        set_req(0, 0, 1'b1, 1'b0, 8'h12, 16'h0);
        @(posedge clk); #1;
        m0_req = 1'b0;
        k = -1; rd = '0;
        for (int c = 1; c < 12 && k < 0; c++) begin
            @(negedge clk);
            if (m0_ack) begin k = c; rd = m0_rdata; end
            @(posedge clk); #1;
        end
        nchecks++;
        if (k !== 3 || rd !== 16'hBEEF) begin
            nfail++; $display("FAIL req_drop k=%0d rd=%h exp k=3 rd=beef", k, rd);
        end
    endtask

    task automatic test_back_to_back();
        int i0, i1, nack, last_c, wc, who, k, oth;
        logic [15:0] rd;
        bit a0, a1;
        do_reset();
        i0 = 0; i1 = 0; nack = 0; last_c = -1; wc = 0;
        set_req(0, 0, 1'b1, 1'b1, 8'h40, 16'h1000);
        set_req(0, 1, 1'b1, 1'b1, 8'h50, 16'h2000);
        for (int c = 0; c < 40 && nack < 8; c++) begin
            @(negedge clk);
            a0 = m0_ack; a1 = m1_ack;
            if (ram_we) wc++;
            if (a0 || a1) begin
                who = a1 ? 1 : 0;
                nchecks++;
                if ((a0 && a1) || who !== (nack % 2)) begin
                    nfail++; $display("FAIL stream_order n=%0d acks=%b%b exp master %0d", nack, a1, a0, nack % 2);
                end
                nchecks++;
                if ((nack == 0 && c !== 2) || (nack > 0 && c - last_c !== 3)) begin
                    nfail++; $display("FAIL stream_spacing n=%0d cycle=%0d prev=%0d exp 3 apart", nack, c, last_c);
                end
                last_c = c;
                nack++;
            end
            @(posedge clk); #1;
            if (a0) begin
                i0++;
                if (i0 < 4) set_req(0, 0, 1'b1, 1'b1, 8'(8'h40 + i0), 16'(16'h1000 + i0));
                else m0_req = 1'b0;
            end
            if (a1) begin
                i1++;
                if (i1 < 4) set_req(0, 1, 1'b1, 1'b1, 8'(8'h50 + i1), 16'(16'h2000 + i1));
                else m1_req = 1'b0;
            end
        end
        nchecks++;
        if (nack !== 8 || wc !== 8) begin
            nfail++; $display("FAIL stream_count acks=%0d we_cyc=%0d exp 8 8", nack, wc);
        end
        run_txn(0, 0, 1'b0, 8'h43, 16'h0, k, rd, wc, oth);
        nchecks++;
        if (rd !== 16'h1003) begin
            nfail++; $display("FAIL stream_m0_data got=%h exp=1003", rd);
        end
        run_txn(0, 1, 1'b0, 8'h53, 16'h0, k, rd, wc, oth);
        nchecks++;
        if (rd !== 16'h2003) begin
            nfail++; $display("FAIL stream_m1_data got=%h exp=2003", rd);
        end
    endtask

    task automatic test_reset_mid();
        int k, wc, oth, k0, k1, dbl, acks;
        logic [15:0] rd, rd0, rd1;
        run_txn(0, 1, 1'b1, 8'h10, 16'h7777, k, rd, wc, oth);
        @(posedge clk); #1;
        set_req(0, 0, 1'b1, 1'b1, 8'h20, 16'hDEAD);
        @(posedge clk);
        @(negedge clk);
        nchecks++;
        if (ram_we !== 1'b1 || ram_addr !== 8'h20) begin
            nfail++; $display("FAIL mid_access we=%b addr=%h exp we=1 addr=20", ram_we, ram_addr);
        end
        rst = 1'b1;
        #1;
        nchecks++;
        if ({ram_we, ram_addr, ram_din, m0_ack, m1_ack, m0_rdata, m1_rdata} !== 59'd0) begin
            nfail++; $display("FAIL async_abort got=%h exp=0",
                              {ram_we, ram_addr, ram_din, m0_ack, m1_ack, m0_rdata, m1_rdata});
        end
        m0_req = 1'b0;
        acks = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (m0_ack || m1_ack || ram_we) acks++;
        end
        nchecks++;
        if (acks !== 0) begin
            nfail++; $display("FAIL no_ack_after_abort got=%0d exp=0", acks);
        end
        run_pair(1'b1, 8'h21, 16'h0101, 8'h22, 16'h0202, k0, k1, rd0, rd1, dbl);
        nchecks++;
        if (k0 !== 2 || k1 !== 5) begin
            nfail++; $display("FAIL post_reset_grant k0=%0d k1=%0d exp k0=2 k1=5", k0, k1);
        end
    endtask

    task automatic test_latency2();
        int k, wc, oth;
        logic [15:0] rd;
        run_txn(1, 0, 1'b1, 8'h80, 16'hA5A5, k, rd, wc, oth);
        nchecks++;
        if (k !== 2 || wc !== 1) begin
            nfail++; $display("FAIL rl2_write k=%0d we_cyc=%0d exp k=2 we_cyc=1", k, wc);
        end
        run_txn(1, 0, 1'b1, 8'h81, 16'h1234, k, rd, wc, oth);
        run_txn(1, 0, 1'b0, 8'h81, 16'h0, k, rd, wc, oth);
        nchecks++;
        if (k !== 4 || rd !== 16'h1234) begin
            nfail++; $display("FAIL rl2_read81 k=%0d rd=%h exp k=4 rd=1234", k, rd);
        end
        run_txn(1, 0, 1'b0, 8'h80, 16'h0, k, rd, wc, oth);
        nchecks++;
        if (k !== 4 || rd !== 16'hA5A5 || oth !== 0) begin
            nfail++; $display("FAIL rl2_read80 k=%0d rd=%h m1_acks=%0d exp k=4 rd=a5a5 m1_acks=0", k, rd, oth);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_tie();
        test_m1_only();
        test_wrap();
        test_req_drop();
        test_back_to_back();
        test_reset_mid();
        test_latency2();
        $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
        $finish;
    end

endmodule
